// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c_master among NUM_REQ requesters,
// with a watchdog that pulses the master's enable low to recover a stalled bus.
module i2c_master_arbiter #(
  parameter int          NUM_REQ    = 4,
  parameter int          ADDR_BYTES = 1,
  parameter int          DATA_BYTES = 2,
  parameter int          ST_WIDTH   = 1 + ADDR_BYTES + DATA_BYTES,
  parameter logic [19:0] TIMEOUT    = 20'hFFFFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_rnw,
  input  logic [NUM_REQ-1:0]            req_data_size,
  input  logic [7*NUM_REQ-1:0]          req_chip_addr,
  input  logic [8*ADDR_BYTES*NUM_REQ-1:0] req_reg_addr,
  input  logic [8*DATA_BYTES*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [8*DATA_BYTES-1:0]       rsp_rdata,
  output logic                          rsp_nack,
  output logic                          rsp_timeout,
  output logic [2:0]                    grant_id,
  output logic                          m_enable,
  output logic [6:0]                    m_chip_addr,
  output logic [8*ADDR_BYTES-1:0]       m_reg_addr,
  output logic [8*DATA_BYTES-1:0]       m_data_in,
  output logic                          m_data_size,
  output logic                          m_write_en,
  output logic                          m_read_en,
  output logic                          m_write_mode,
  input  logic [8*DATA_BYTES-1:0]       m_data_out,
  input  logic [ST_WIDTH-1:0]           m_status,
  input  logic                          m_done,
  input  logic                          m_busy
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, RECOVER} state_t;

  state_t      state;
  logic [2:0]  ptr;
  logic [19:0] wd_cnt;
  logic [1:0]  rec_cnt;
  logic        rnw_q;

  logic        found;
  logic [2:0]  sel;
  int unsigned idx;

  assign m_write_mode = 1'b0;

  // Search upward from the last grant so the previous winner has lowest priority.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= 3'(NUM_REQ - 1);
      wd_cnt      <= '0;
      rec_cnt     <= '0;
      rnw_q       <= 1'b0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
      grant_id    <= '0;
      m_enable    <= 1'b0;
      m_chip_addr <= '0;
      m_reg_addr  <= '0;
      m_data_in   <= '0;
      m_data_size <= 1'b0;
      m_write_en  <= 1'b0;
      m_read_en   <= 1'b0;
    end else begin
      req_ready  <= '0;
      rsp_valid  <= '0;
      m_write_en <= 1'b0;
      m_read_en  <= 1'b0;
      case (state)
        IDLE: begin
          m_enable <= 1'b1;
          if (found) begin
            state          <= ISSUE;
            grant_id       <= sel;
            ptr            <= sel;
            req_ready[sel] <= 1'b1;
            rnw_q          <= req_rnw[sel];
            m_write_en     <= ~req_rnw[sel];
            m_read_en      <= req_rnw[sel];
            m_chip_addr    <= req_chip_addr[7*sel +: 7];
            m_reg_addr     <= req_reg_addr[AW*sel +: AW];
            m_data_in      <= req_wdata[DW*sel +: DW];
            m_data_size    <= req_data_size[sel];
          end
        end
        ISSUE: begin
          wd_cnt <= '0;
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (wd_cnt == TIMEOUT) begin
            state    <= RECOVER;
            m_enable <= 1'b0;
            rec_cnt  <= '0;
          end else begin
            wd_cnt <= wd_cnt + 20'd1;
            if (m_busy) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // done is checked first so it wins over a coincident watchdog expiry
          if (m_done) begin
            if (rnw_q) rsp_rdata <= m_data_out;
            rsp_nack            <= |m_status;
            rsp_timeout         <= 1'b0;
            rsp_valid[grant_id] <= 1'b1;
            state               <= RESP;
          end else if (wd_cnt == TIMEOUT) begin
            state    <= RECOVER;
            m_enable <= 1'b0;
            rec_cnt  <= '0;
          end else begin
            wd_cnt <= wd_cnt + 20'd1;
          end
        end
        RECOVER: begin
          if (rec_cnt == 2'd3) begin
            m_enable            <= 1'b1;
            rsp_timeout         <= 1'b1;
            rsp_nack            <= 1'b1;
            rsp_rdata           <= '0;
            rsp_valid[grant_id] <= 1'b1;
            state               <= RESP;
          end else begin
            rec_cnt <= rec_cnt + 2'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: stimulus queues expected issues/responses,
// independent monitors pop and compare; a behavioural master model answers commands.
module tb_i2c_master_arbiter;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid, req_ready, req_rnw, req_data_size, rsp_valid;
  logic [7*NR-1:0]  req_chip_addr;
  logic [8*NR-1:0]  req_reg_addr;
  logic [16*NR-1:0] req_wdata;
  logic [15:0]   rsp_rdata;
  logic          rsp_nack, rsp_timeout;
  logic [2:0]    grant_id;
  logic          m_enable, m_data_size, m_write_en, m_read_en, m_write_mode;
  logic [6:0]    m_chip_addr;
  logic [7:0]    m_reg_addr;
  logic [15:0]   m_data_in, m_data_out;
  logic [2:0]    m_status;
  logic          m_done, m_busy;

  i2c_master_arbiter #(.NUM_REQ(NR), .ADDR_BYTES(1), .DATA_BYTES(2), .TIMEOUT(20'd100)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_data_size(req_data_size), .req_chip_addr(req_chip_addr),
    .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
    .rsp_timeout(rsp_timeout), .grant_id(grant_id),
    .m_enable(m_enable), .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr),
    .m_data_in(m_data_in), .m_data_size(m_data_size), .m_write_en(m_write_en),
    .m_read_en(m_read_en), .m_write_mode(m_write_mode), .m_data_out(m_data_out),
    .m_status(m_status), .m_done(m_done), .m_busy(m_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       v_valid [NR];
  logic       v_rnw   [NR];
  logic       v_size  [NR];
  logic [6:0] v_chip  [NR];
  logic [7:0] v_reg   [NR];
  logic [15:0] v_data [NR];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_valid[i]            = v_valid[i];
      req_rnw[i]              = v_rnw[i];
      req_data_size[i]        = v_size[i];
      req_chip_addr[7*i +: 7] = v_chip[i];
      req_reg_addr[8*i +: 8]  = v_reg[i];
      req_wdata[16*i +: 16]   = v_data[i];
    end
  end

  typedef struct packed {
    logic [2:0] id; logic rnw; logic size; logic [6:0] chip; logic [7:0] ra; logic [15:0] data;
  } iss_t;
  typedef struct packed {
    logic [2:0] id; logic [15:0] rdata; logic nack; logic to; logic [6:0] chip;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   rec_q[$];
  int   checks = 0;
  int   errors = 0;
  int   iss_cyc = 0;

  logic [15:0] model_rdata  = '0;
  logic [2:0]  model_status = '0;
  logic        model_stall  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural i2c_master: busy one cycle after the command, done three cycles later.
  initial begin
    m_busy = 0; m_done = 0; m_data_out = '0; m_status = '0;
    forever begin
      @(negedge clk);
      if (reset && (m_write_en || m_read_en)) begin
        @(negedge clk);
        m_busy = 1;
        if (model_stall) begin
          for (int n = 0; n < 2000 && reset && m_enable; n++) @(negedge clk);
          m_busy = 0;
        end else begin
          repeat (3) @(negedge clk);
          m_data_out = model_rdata; m_status = model_status; m_done = 1;
          @(negedge clk);
          m_done = 0; m_busy = 0; m_status = '0;
        end
      end
    end
  end

  // Issue monitor
  initial begin
    iss_t e;
    forever begin
      @(negedge clk);
      if (reset && (m_write_en || m_read_en)) begin
        if (iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected: got grant %0d expected none", grant_id);
        end else begin
          e = iss_q.pop_front();
          iss_cyc = cyc;
          chk("issue_grant_id", 64'(grant_id), 64'(e.id));
          chk("issue_req_ready", 64'(req_ready), 64'(4'b1 << e.id));
          chk("issue_en", {62'd0, m_write_en, m_read_en}, {62'd0, ~e.rnw, e.rnw});
          chk("issue_chip", 64'(m_chip_addr), 64'(e.chip));
          chk("issue_reg", 64'(m_reg_addr), 64'(e.ra));
          chk("issue_size", 64'(m_data_size), 64'(e.size));
          if (!e.rnw) chk("issue_wdata", 64'(m_data_in), 64'(e.data));
          @(negedge clk);
          chk("issue_pulse_end", {61'd0, m_write_en, m_read_en, |req_ready}, 64'd0);
        end
      end
    end
  end

  // Response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (reset && (|rsp_valid)) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rsp_valid %b expected none", rsp_valid);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(4'b1 << e.id));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("rsp_flags", {62'd0, rsp_nack, rsp_timeout}, {62'd0, e.nack, e.to});
          chk("rsp_chip_stable", 64'(m_chip_addr), 64'(e.chip));
        end
      end
    end
  end

  // Recovery monitor: measures each m_enable low run while out of reset
  initial begin
    int low = 0;
    int start = 0;
    forever begin
      @(negedge clk);
      if (!reset) low = 0;
      else if (!m_enable) begin
        if (low == 0) start = cyc;
        low++;
      end else if (low != 0) begin
        if (rec_q.size() == 0) chk("recover_unexpected", 64'(low), 64'd0);
        else begin
          void'(rec_q.pop_front());
          chk("recover_len", 64'(low), 64'd4);
          chk("recover_delay_in_window",
              64'((start - iss_cyc) >= 95 && (start - iss_cyc) <= 110), 64'd1);
        end
        low = 0;
      end
    end
  end

  task automatic submit(input int id, input logic rnw, input logic size,
                        input logic [6:0] chip, input logic [7:0] ra, input logic [15:0] data);
    bit got = 0;
    v_rnw[id] = rnw; v_size[id] = size; v_chip[id] = chip; v_reg[id] = ra; v_data[id] = data;
    v_valid[id] = 1'b1;
    for (int n = 0; n < 500 && !got; n++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1;
    end
    v_valid[id] = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL ready_timeout: requester %0d got no req_ready expected within 500 cycles", id);
    end
  endtask

  task automatic drain(input int limit);
    bit empty = 0;
    for (int n = 0; n < limit && !empty; n++) begin
      @(negedge clk);
      empty = (iss_q.size() == 0 && rsp_q.size() == 0);
    end
    repeat (3) @(negedge clk);
    if (!empty) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d issues %0d responses pending expected 0",
               iss_q.size(), rsp_q.size());
      iss_q.delete(); rsp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rsp_side"},
        {25'd0, req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, grant_id}, 64'd0);
    chk({tag, "_master_side"},
        {27'd0, m_enable, m_chip_addr, m_reg_addr, m_data_in, m_data_size,
         m_write_en, m_read_en, m_write_mode}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    for (int i = 0; i < NR; i++) begin
      v_valid[i] = 0; v_rnw[i] = 0; v_size[i] = 0; v_chip[i] = '0; v_reg[i] = '0; v_data[i] = '0;
    end
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #1 reset = 1'b1;
    @(negedge clk);
    chk("m_enable_after_reset", 64'(m_enable), 64'd1);

    // single write; rsp_rdata must hold its reset value
    model_rdata = 16'hDEAD;
    iss_q.push_back('{3'd1, 1'b0, 1'b1, 7'h50, 8'h10, 16'hBEEF});
    rsp_q.push_back('{3'd1, 16'h0000, 1'b0, 1'b0, 7'h50});
    submit(1, 1'b0, 1'b1, 7'h50, 8'h10, 16'hBEEF);
    drain(200);

    // read
    model_rdata = 16'h1234;
    iss_q.push_back('{3'd2, 1'b1, 1'b1, 7'h48, 8'h00, 16'h0000});
    rsp_q.push_back('{3'd2, 16'h1234, 1'b0, 1'b0, 7'h48});
    submit(2, 1'b1, 1'b1, 7'h48, 8'h00, 16'h0000);
    drain(200);

    // contention from reset: 0,1,2,3 then 0 again
    do_reset();
    model_rdata = 16'h7777;
    iss_q.push_back('{3'd0, 1'b0, 1'b1, 7'h10, 8'hA0, 16'h1000});
    iss_q.push_back('{3'd1, 1'b0, 1'b1, 7'h11, 8'hA1, 16'h1001});
    iss_q.push_back('{3'd2, 1'b0, 1'b0, 7'h12, 8'hA2, 16'h0002});
    iss_q.push_back('{3'd3, 1'b0, 1'b1, 7'h13, 8'hA3, 16'h1003});
    iss_q.push_back('{3'd0, 1'b0, 1'b1, 7'h14, 8'hA4, 16'h1004});
    rsp_q.push_back('{3'd0, 16'h0000, 1'b0, 1'b0, 7'h10});
    rsp_q.push_back('{3'd1, 16'h0000, 1'b0, 1'b0, 7'h11});
    rsp_q.push_back('{3'd2, 16'h0000, 1'b0, 1'b0, 7'h12});
    rsp_q.push_back('{3'd3, 16'h0000, 1'b0, 1'b0, 7'h13});
    rsp_q.push_back('{3'd0, 16'h0000, 1'b0, 1'b0, 7'h14});
    fork
      begin
        submit(0, 1'b0, 1'b1, 7'h10, 8'hA0, 16'h1000);
        submit(0, 1'b0, 1'b1, 7'h14, 8'hA4, 16'h1004);
      end
      submit(1, 1'b0, 1'b1, 7'h11, 8'hA1, 16'h1001);
      submit(2, 1'b0, 1'b0, 7'h12, 8'hA2, 16'h0002);
      submit(3, 1'b0, 1'b1, 7'h13, 8'hA3, 16'h1003);
    join
    drain(300);

    // NACK on a one-byte read
    model_rdata = 16'h00AB; model_status = 3'b010;
    iss_q.push_back('{3'd3, 1'b1, 1'b0, 7'h22, 8'h05, 16'h0000});
    rsp_q.push_back('{3'd3, 16'h00AB, 1'b1, 1'b0, 7'h22});
    submit(3, 1'b1, 1'b0, 7'h22, 8'h05, 16'h0000);
    drain(200);
    model_status = 3'b000;

    // stalled master -> watchdog recovery, then a normal read
    model_stall = 1'b1;
    iss_q.push_back('{3'd0, 1'b0, 1'b1, 7'h3C, 8'h20, 16'hCAFE});
    rsp_q.push_back('{3'd0, 16'h0000, 1'b1, 1'b1, 7'h3C});
    rec_q.push_back(1);
    submit(0, 1'b0, 1'b1, 7'h3C, 8'h20, 16'hCAFE);
    drain(1000);
    model_stall = 1'b0;
    model_rdata = 16'h5A5A;
    iss_q.push_back('{3'd1, 1'b1, 1'b1, 7'h11, 8'h02, 16'h0000});
    rsp_q.push_back('{3'd1, 16'h5A5A, 1'b0, 1'b0, 7'h11});
    submit(1, 1'b1, 1'b1, 7'h11, 8'h02, 16'h0000);
    drain(200);

    // reset while waiting for done
    model_stall = 1'b1;
    iss_q.push_back('{3'd2, 1'b0, 1'b1, 7'h33, 8'h44, 16'h5555});
    submit(2, 1'b0, 1'b1, 7'h33, 8'h44, 16'h5555);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    model_stall = 1'b0;
    #1 reset = 1'b1;
    iss_q.push_back('{3'd0, 1'b0, 1'b1, 7'h01, 8'h11, 16'hAAAA});
    iss_q.push_back('{3'd2, 1'b0, 1'b1, 7'h02, 8'h22, 16'hBBBB});
    rsp_q.push_back('{3'd0, 16'h0000, 1'b0, 1'b0, 7'h01});
    rsp_q.push_back('{3'd2, 16'h0000, 1'b0, 1'b0, 7'h02});
    @(negedge clk);
    fork
      submit(2, 1'b0, 1'b1, 7'h02, 8'h22, 16'hBBBB);
      submit(0, 1'b0, 1'b1, 7'h01, 8'h11, 16'hAAAA);
    join
    drain(200);
    chk("recover_events_left", 64'(rec_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
Round-robin command arbiter and sequencer sharing one i2c_master between NUM_REQ on-chip requesters (sensor pollers, config loaders, debug port). Each requester submits a register read or write through a valid/ready handshake. The block latches the command, drives the master's command inputs, waits for done, and returns read data, ACK status and a timeout flag. A watchdog recovers the shared bus if the master stalls (e.g. SCL held low by a slave).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_BYTES, 1, register address bytes; must equal the attached master's ADDR_BYTES
DATA_BYTES, 2, data bytes; must equal the master's DATA_BYTES
ST_WIDTH, 1+ADDR_BYTES+DATA_BYTES, master status width
TIMEOUT, 20'hFFFFF, clk cycles allowed from issue to done before recovery

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester command valid
req_ready  out  NUM_REQ  one-cycle accept pulse per requester
req_rnw  in  NUM_REQ  1 = read, 0 = write
req_data_size  in  NUM_REQ  0 = one data byte, 1 = DATA_BYTES
req_chip_addr  in  7*NUM_REQ  packed 7-bit slave addresses, requester i at [7i+6:7i]
req_reg_addr  in  8*ADDR_BYTES*NUM_REQ  packed register addresses
req_wdata  in  8*DATA_BYTES*NUM_REQ  packed write data
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_rdata  out  8*DATA_BYTES  read data (shared, valid with rsp_valid)
rsp_nack  out  1  1 if any ACK slot of the transfer saw NACK
rsp_timeout  out  1  1 if the transfer was aborted by the watchdog
grant_id  out  3  index of the current or last granted requester
m_enable  out  1  to master enable
m_chip_addr  out  7  to master chip_addr
m_reg_addr  out  8*ADDR_BYTES  to master reg_addr
m_data_in  out  8*DATA_BYTES  to master data_in
m_data_size  out  1  to master data_size
m_write_en  out  1  to master write_en
m_read_en  out  1  to master read_en
m_write_mode  out  1  to master write_mode; constant 0 (single transfers only)
m_data_out  in  8*DATA_BYTES  from master data_out
m_status  in  ST_WIDTH  from master status
m_done  in  1  from master done
m_busy  in  1  from master busy

Behaviour:
- Reset (async, active-low) clears state to IDLE and sets every output to 0; grant pointer = NUM_REQ-1 so requester 0 has top priority. m_enable = 0 during reset and rises on the first clk edge after release.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, RECOVER.
- IDLE: when any req_valid is high, pick the first set bit searching upward from pointer+1 with wrap. Go to ISSUE. In the same edge, latch that requester's fields into the m_* command registers, set grant_id, update the pointer and register req_ready[g] = 1.
- ISSUE (1 cycle): req_ready[g] = 1. m_write_en = ~rnw and m_read_en = rnw for exactly this cycle. Next state is WAIT_BUSY.
- WAIT_BUSY: wait for m_busy = 1, then go to WAIT_DONE.
- WAIT_DONE: wait for m_done = 1. Then latch m_data_out into rsp_rdata (only when rnw; otherwise rsp_rdata holds), set rsp_nack = |m_status, set rsp_timeout = 0, and go to RESP.
- RESP (1 cycle): rsp_valid[g] = 1; then go to IDLE. rsp_rdata, rsp_nack and rsp_timeout hold until the next RESP.
- m_chip_addr, m_reg_addr, m_data_in and m_data_size stay stable from ISSUE until the next grant.
- Watchdog: a 20-bit counter clears in ISSUE and increments in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT:
  - go to RECOVER and drive m_enable = 0 for 4 cycles (resets the master);
  - then set rsp_timeout = 1, rsp_nack = 1, rsp_rdata = 0, and go to RESP.
- Requesters must hold valid and fields until they see req_ready. A requester re-asserting valid right after RESP is arbitrated normally. A request dropped before grant is ignored.
- Only one transfer is outstanding. A new grant is never made before RESP completes.
- Minimum issue-to-issue spacing is ISSUE + WAIT_BUSY(≥1) + WAIT_DONE + RESP + IDLE.
- Simultaneous m_done and watchdog expiry: done wins.

Test Plan:
- Single write: req 1 write, chip 0x50, reg 0x10, wdata 0xBEEF, size 1 -> req_ready[1] for 1 cycle; m_write_en for 1 cycle with m_chip_addr=0x50 and m_data_in=0xBEEF; after the model's done, rsp_valid[1] for 1 cycle with rsp_nack=0 and rsp_timeout=0.
- Read: req 2 read, chip 0x48, reg 0x00; model returns 0x1234 -> m_read_en for 1 cycle; rsp_rdata=0x1234; rsp_valid[2] only.
- Contention: all 4 valid continuously after reset -> grant order 0,1,2,3,0; no requester granted twice while another is waiting.
- NACK: model reports m_status=3'b010 -> rsp_nack=1, rsp_timeout=0.
- Stall: model never asserts done (TIMEOUT set to 100) -> m_enable low for exactly 4 cycles ~100 cycles after ISSUE; rsp_timeout=1; the next request completes normally.
- Reset mid-transfer: assert reset during WAIT_DONE -> all outputs 0 immediately (async); after release, requester 0 wins the first arbitration.
